vec_dot_seq: RTL
================

// Module: vec_dot_seq
// PURPOSE
//  Sequential FP64 dot-product stage. Consumes a packed 3-vector produced by
//  the vector-subtract stage (e.g. ray origin minus sphere centre) together
//  with a second vector, and returns a.b as a packed double.
//  Feeds the ray-sphere discriminant / shading stages.
//  One shared multiply-accumulate iterates x, y, z over 3 cycles.
//  Arithmetic is behavioural IEEE-754 double ($bitstoreal/$realtobits),
//  the same as in all other vector stages.
// PARAMETERS
//  COMP_W   64   width of one packed double component
//  VEC_W    192  packed vector width, 3*COMP_W; x=[191:128] y=[127:64] z=[63:0]
// PORTS
//  clk        in   1      single clock, all state on posedge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      a/b presented
//  in_ready   out  1      stage can accept a/b this cycle
//  in_a       in   VEC_W  vector a, packed doubles
//  in_b       in   VEC_W  vector b, packed doubles
//  out_valid  out  1      result held on out_dot
//  out_ready  in   1      downstream accepts result
//  out_dot    out  COMP_W a.x*b.x + a.y*b.y + a.z*b.z, IEEE double bits
//  out_neg    out  1      out_dot sign bit set and value not NaN (back-facing)
//  out_nan    out  1      result is NaN (any NaN input, or inf*0)
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, acc=+0.0, in_ready=0 while asserted,
//   out_valid=0, out_dot=64'h0, out_neg=0, out_nan=0; operand regs cleared.
//  Handshake: transfer when valid&&ready on the same edge. in_ready =
//   (state==IDLE) || (state==DONE && out_ready); combinational, no in_valid path.
//  Once accepted, in_a/in_b are latched; inputs may change afterwards.
//  FSM: IDLE -accept-> MX -> MY -> MZ -> DONE.
//   MX: acc = a.x*b.x (overwrite, never add to stale acc).
//   MY: acc += a.y*b.y.  MZ: acc += a.z*b.z, result registered.
//   DONE: out_valid=1; out_dot/out_neg/out_nan stable until out_ready.
//   DONE & out_ready & in_valid -> MX (back-to-back; new operands latched).
//   DONE & out_ready & !in_valid -> IDLE; out_valid drops, out_dot holds value.
//  Latency: accept on edge N -> out_valid high after edge N+3.
//   Peak throughput one result per 4 cycles.
//  Summation order fixed x, y, z (bit-exact vs software reference in that order).
//  out_valid never depends combinationally on out_ready.
//  out_neg for -0.0 result = 1 (sign bit); for NaN = 0.
//  Reset mid-operation (MX..DONE): operation discarded, no output pulse.
//  Inputs ignored while in MX/MY/MZ (in_ready=0).
// STRUCTURE
//  Shared package basicray_pkg: COMP_W, VEC_W, field offsets X_HI/Y_HI/Z_HI,
//   functions vec_x/vec_y/vec_z(vec) returning component slices, FSM state
//   localparams (IDLE,MX,MY,MZ,DONE), FP64 constants ZERO/NAN_MASK.
//  One sub-module: fp64_mac (comb: acc_in, a, b, clear -> acc_out),
//   reused by later normalise/length stages.
// TESTING
//  a=(1,2,3) b=(4,5,6), out_ready=1 -> out_dot=64'h4040000000000000 (32.0),
//   out_valid 3 cycles after accept, neg=0, nan=0.
//  a=(-1,0,0) b=(1,0,0) -> out_dot=64'hBFF0000000000000 (-1.0), out_neg=1.
//  Backpressure: out_ready=0 for 5 cycles in DONE -> out_dot stable,
//   out_valid=1, in_ready=0; release -> one transfer only.
//  Back-to-back: in_valid held with 3 vector pairs, out_ready=1 -> results
//   every 4 cycles, in order, no drops/duplicates; acc not carried over.
//  a.x=NaN (64'h7FF8000000000000), b=(1,1,1) -> out_nan=1, out_neg=0;
//   a=(inf,0,0) b=(0,1,1) -> out_nan=1.
//  rst_n pulsed low in MY -> out_valid=0 immediately; next op (1,1,1).(2,2,2)
//   -> 6.0 (64'h4018000000000000).

Source files
------------

// File: rtl/basicray_pkg.sv
// Shared definitions for the basicray vector stages: packed FP64 vector
// layout, component accessors, FSM state encoding and FP64 constants.
package basicray_pkg;

  localparam int COMP_W = 64;
  localparam int VEC_W  = 3 * COMP_W;

  // Upper bit of each component inside a packed vector.
  localparam int X_HI = 3 * COMP_W - 1;
  localparam int Y_HI = 2 * COMP_W - 1;
  localparam int Z_HI = 1 * COMP_W - 1;

  // +0.0 and the exponent field of an IEEE-754 double.
  localparam logic [COMP_W-1:0] ZERO     = 64'h0000_0000_0000_0000;
  localparam logic [COMP_W-1:0] NAN_MASK = 64'h7FF0_0000_0000_0000;

  typedef enum logic [2:0] {
    IDLE,
    MX,
    MY,
    MZ,
    DONE
  } state_t;

  function automatic logic [COMP_W-1:0] vec_x(input logic [VEC_W-1:0] v);
    return v[X_HI -: COMP_W];
  endfunction

  function automatic logic [COMP_W-1:0] vec_y(input logic [VEC_W-1:0] v);
    return v[Y_HI -: COMP_W];
  endfunction

  function automatic logic [COMP_W-1:0] vec_z(input logic [VEC_W-1:0] v);
    return v[Z_HI -: COMP_W];
  endfunction

  // All-ones exponent with a non-zero mantissa.
  function automatic logic fp64_is_nan(input logic [COMP_W-1:0] d);
    return ((d & NAN_MASK) == NAN_MASK) && (d[51:0] != 52'd0);
  endfunction

endpackage

// File: rtl/fp64_mac.sv
// Combinational FP64 multiply-accumulate: acc_out = (clear ? 0 : acc_in) + a*b.
// When clear is set the product is returned directly so a stale accumulator
// can never leak in (and -0.0 products keep their sign).
module fp64_mac
  import basicray_pkg::*;
(
  input  logic [COMP_W-1:0] acc_in,
  input  logic [COMP_W-1:0] a,
  input  logic [COMP_W-1:0] b,
  input  logic              clear,
  output logic [COMP_W-1:0] acc_out
);

  // Behavioural IEEE-754 double multiply-add, product first then the sum.
  always_comb begin
    if (clear) begin
      acc_out = $realtobits($bitstoreal(a) * $bitstoreal(b));
    end else begin
      acc_out = $realtobits($bitstoreal(acc_in) + ($bitstoreal(a) * $bitstoreal(b)));
    end
  end

endmodule

// File: rtl/vec_dot_seq.sv
// Sequential FP64 dot product a.b using one shared MAC stepped over x, y, z.
// Accept -> MX -> MY -> MZ -> DONE; the result is held in DONE until taken.
module vec_dot_seq
  import basicray_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [VEC_W-1:0]  in_a,
  input  logic [VEC_W-1:0]  in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [COMP_W-1:0] out_dot,
  output logic              out_neg,
  output logic              out_nan
);

  state_t             state, state_nxt;
  logic [VEC_W-1:0]   a_q, b_q;
  logic [COMP_W-1:0]  acc_q;
  logic [COMP_W-1:0]  mac_a, mac_b, mac_out;
  logic               mac_clear;
  logic               accept;

  // Ready is gated by rst_n so nothing is offered while reset is held.
  assign in_ready  = rst_n && ((state == IDLE) || ((state == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);

  // Next-state logic for the accept / iterate / hold sequence.
  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = MX;
      MX:      state_nxt = MY;
      MY:      state_nxt = MZ;
      MZ:      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = in_valid ? MX : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: non-blocking for all sequential state so every register samples pre-edge values.
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Route the component for the current step into the shared MAC.
  always_comb begin
    mac_a     = vec_z(a_q);
    mac_b     = vec_z(b_q);
    mac_clear = (state == MX);
    unique case (state)
      MX: begin
        mac_a = vec_x(a_q);
        mac_b = vec_x(b_q);
      end
      MY: begin
        mac_a = vec_y(a_q);
        mac_b = vec_y(b_q);
      end
      default: ;
    endcase
  end

  fp64_mac u_mac (
    .acc_in  (acc_q),
    .a       (mac_a),
    .b       (mac_b),
    .clear   (mac_clear),
    .acc_out (mac_out)
  );

  // Operand capture, accumulation and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= ZERO;
      out_dot <= ZERO;
      out_neg <= 1'b0;
      out_nan <= 1'b0;
    end else begin
      if (accept) begin
        a_q <= in_a;
        b_q <= in_b;
      end
      if ((state == MX) || (state == MY) || (state == MZ)) begin
        acc_q <= mac_out;
      end
      if (state == MZ) begin
        out_dot <= mac_out;
        out_nan <= fp64_is_nan(mac_out);
        out_neg <= mac_out[COMP_W-1] && !fp64_is_nan(mac_out);
      end
    end
  end

endmodule
